// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man autopilot: move directions and pilot FSM states.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        CHASE  = 3'd2,
        DONE   = 3'd3,
        CAUGHT = 3'd4
    } pilot_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pacman_dir_sel.sv
// Move direction selector: target-seeking choice with a free-cell fallback.
// Ghost avoidance is compiled in when PACMAN_PILOT_GHOST_AVOID_EN is defined.
module pacman_dir_sel
    import pacman_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic [WIDTH-1:0]             pac_x,
    input  logic [HEIGHT-1:0]            pac_y,
    input  logic [WIDTH-1:0]             tgt_x,
    input  logic [HEIGHT-1:0]            tgt_y,
    input  logic [WIDTH-1:0]             ghost_x,
    input  logic [HEIGHT-1:0]            ghost_y,
    input  logic [WIDTH-1:0][HEIGHT-1:0] walls,
    output dir_e                         dir
);

    // Cells outside the grid (including coordinate wrap-around) read as blocked.
    function automatic logic blocked(input logic [WIDTH-1:0] x, input logic [HEIGHT-1:0] y);
        logic b;
        b = 1'b1;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < HEIGHT; j++)
                if (x == WIDTH'(i) && y == HEIGHT'(j))
                    b = walls[i][j];
        return b;
    endfunction

    logic [WIDTH-1:0]  dest_x [4];
    logic [HEIGHT-1:0] dest_y [4];
    logic [3:0]        free_dir;
    logic [7:0]        cand_ok;
    dir_e              cand_dir [8];
    dir_e              plain_dir;

    // Destination per direction, indexed by the dir_e encoding.
    always_comb begin
        dest_x[0] = pac_x;              dest_y[0] = pac_y - HEIGHT'(1);
        dest_x[1] = pac_x;              dest_y[1] = pac_y + HEIGHT'(1);
        dest_x[2] = pac_x - WIDTH'(1);  dest_y[2] = pac_y;
        dest_x[3] = pac_x + WIDTH'(1);  dest_y[3] = pac_y;
        for (int d = 0; d < 4; d++)
            free_dir[d] = !blocked(dest_x[d], dest_y[d]);
    end

    // Candidates in priority order: target-seeking first, then plain fallback.
    always_comb begin
        logic hit;
        cand_ok[0] = (tgt_x < pac_x) && free_dir[2];  cand_dir[0] = LEFT;
        cand_ok[1] = (tgt_x > pac_x) && free_dir[3];  cand_dir[1] = RIGHT;
        cand_ok[2] = (tgt_y < pac_y) && free_dir[0];  cand_dir[2] = UP;
        cand_ok[3] = (tgt_y > pac_y) && free_dir[1];  cand_dir[3] = DOWN;
        cand_ok[4] = free_dir[0];                     cand_dir[4] = UP;
        cand_ok[5] = free_dir[1];                     cand_dir[5] = DOWN;
        cand_ok[6] = free_dir[2];                     cand_dir[6] = LEFT;
        cand_ok[7] = free_dir[3];                     cand_dir[7] = RIGHT;
        plain_dir = UP;
        hit       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!hit && cand_ok[k]) begin
                plain_dir = cand_dir[k];
                hit       = 1'b1;
            end
        end
    end

`ifdef PACMAN_PILOT_GHOST_AVOID_EN
    function automatic logic near_ghost(input logic [WIDTH-1:0] cx, input logic [HEIGHT-1:0] cy);
        logic x_eq, y_eq, x_adj, y_adj;
        x_eq  = (cx == ghost_x);
        y_eq  = (cy == ghost_y);
        x_adj = ({1'b0, cx} == {1'b0, ghost_x} + (WIDTH+1)'(1)) ||
                ({1'b0, ghost_x} == {1'b0, cx} + (WIDTH+1)'(1));
        y_adj = ({1'b0, cy} == {1'b0, ghost_y} + (HEIGHT+1)'(1)) ||
                ({1'b0, ghost_y} == {1'b0, cy} + (HEIGHT+1)'(1));
        return (x_eq && (y_eq || y_adj)) || (y_eq && x_adj);
    endfunction

    logic [3:0] ghost_near;

    // Take the first candidate not landing on or next to the ghost; if none, keep the plain pick.
    always_comb begin
        logic safe_hit;
        dir_e safe_dir;
        for (int d = 0; d < 4; d++)
            ghost_near[d] = near_ghost(dest_x[d], dest_y[d]);
        safe_hit = 1'b0;
        safe_dir = UP;
        for (int k = 0; k < 8; k++) begin
            if (!safe_hit && cand_ok[k] && !ghost_near[cand_dir[k]]) begin
                safe_dir = cand_dir[k];
                safe_hit = 1'b1;
            end
        end
        dir = safe_hit ? safe_dir : plain_dir;
    end
`else
    logic unused_ghost;
    assign unused_ghost = ^{ghost_x, ghost_y};
    assign dir          = plain_dir;
`endif

endmodule

// File: rtl/pacman_pilot.sv
// Pac-Man autopilot: scans the grid for the nearest candy, then steers toward it.
// Define PACMAN_PILOT_GHOST_AVOID_EN to make the steering avoid the ghost.
module pacman_pilot
    import pacman_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             pacman_x,
    input  logic [HEIGHT-1:0]            pacman_y,
    input  logic [WIDTH-1:0]             ghost_x,
    input  logic [HEIGHT-1:0]            ghost_y,
    input  logic [WIDTH-1:0][HEIGHT-1:0] walls,
    input  logic [WIDTH-1:0][HEIGHT-1:0] candies,
    input  logic                         catch,
    output logic [1:0]                   move,
    output logic                         move_valid,
    output logic [WIDTH-1:0]             target_x,
    output logic [HEIGHT-1:0]            target_y,
    output logic                         target_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         caught,
    output pilot_state_e                 dbg_state
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DW = max_int(WIDTH, HEIGHT) + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    function automatic logic [DW-1:0] manhattan(input logic [WIDTH-1:0] ax, input logic [HEIGHT-1:0] ay,
                                                input logic [WIDTH-1:0] bx, input logic [HEIGHT-1:0] by);
        logic [WIDTH-1:0]  dx;
        logic [HEIGHT-1:0] dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return DW'(dx) + DW'(dy);
    endfunction

    pilot_state_e      state, state_nx;
    logic [XW-1:0]     sx, best_x, tgt_x, abn_x;
    logic [YW-1:0]     sy, best_y, tgt_y, abn_y;
    logic              best_found, abn_valid;
    logic [DW-1:0]     best_dist, cell_dist;
    logic [WIDTH-1:0]  scan_px, last_px;
    logic [HEIGHT-1:0] scan_py, last_py;
    logic [SW-1:0]     stall_cnt;
    logic              scan_last, cell_take, found_now, pos_moved, tgt_gone, stall_hit, scan_enter;
    dir_e              sel_dir;

    assign scan_last = (sx == XW'(WIDTH - 1)) && (sy == YW'(HEIGHT - 1));
    assign cell_dist = manhattan(WIDTH'(sx), HEIGHT'(sy), scan_px, scan_py);
    assign cell_take = (state == SCAN) && candies[sx][sy] &&
                       !(abn_valid && abn_x == sx && abn_y == sy) &&
                       (!best_found || cell_dist < best_dist);
    assign found_now = best_found || cell_take;
    assign pos_moved = (pacman_x != last_px) || (pacman_y != last_py);
    assign tgt_gone  = !candies[tgt_x][tgt_y];
    assign stall_hit = (state == CHASE) && !pos_moved && (stall_cnt == SW'(STALL_LIMIT - 1));

    // catch overrides every other transition; only IDLE ignores it.
    always_comb begin
        state_nx = state;
        if (catch && state != IDLE) begin
            state_nx = CAUGHT;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = SCAN;
                SCAN:    if (scan_last) state_nx = found_now ? CHASE : DONE;
                CHASE:   if (tgt_gone || stall_hit) state_nx = SCAN;
                default: state_nx = state;
            endcase
        end
        scan_enter = (state_nx == SCAN) && (state != SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sx         <= '0;
            sy         <= '0;
            best_x     <= '0;
            best_y     <= '0;
            best_dist  <= '0;
            best_found <= 1'b0;
            tgt_x      <= '0;
            tgt_y      <= '0;
            abn_x      <= '0;
            abn_y      <= '0;
            abn_valid  <= 1'b0;
            scan_px    <= '0;
            scan_py    <= '0;
            last_px    <= '0;
            last_py    <= '0;
            stall_cnt  <= '0;
        end else begin
            state   <= state_nx;
            last_px <= pacman_x;
            last_py <= pacman_y;
            if (scan_enter) begin
                sx         <= '0;
                sy         <= '0;
                best_found <= 1'b0;
                best_dist  <= '0;
                scan_px    <= pacman_x;
                scan_py    <= pacman_y;
            end else if (state == SCAN) begin
                if (cell_take) begin
                    best_x     <= sx;
                    best_y     <= sy;
                    best_dist  <= cell_dist;
                    best_found <= 1'b1;
                end
                if (sy == YW'(HEIGHT - 1)) begin
                    sy <= '0;
                    sx <= sx + XW'(1);
                end else begin
                    sy <= sy + YW'(1);
                end
            end
            // The last scanned cell may itself be the winner.
            if (state == SCAN && state_nx == CHASE) begin
                tgt_x <= cell_take ? sx : best_x;
                tgt_y <= cell_take ? sy : best_y;
            end
            if (state == CHASE && state_nx == CHASE)
                stall_cnt <= pos_moved ? '0 : stall_cnt + SW'(1);
            else
                stall_cnt <= '0;
            if (state_nx == SCAN && stall_hit && !tgt_gone) begin
                abn_x     <= tgt_x;
                abn_y     <= tgt_y;
                abn_valid <= 1'b1;
            end
        end
    end

    pacman_dir_sel #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_dir_sel (
        .pac_x   (pacman_x),
        .pac_y   (pacman_y),
        .tgt_x   (target_x),
        .tgt_y   (target_y),
        .ghost_x (ghost_x),
        .ghost_y (ghost_y),
        .walls   (walls),
        .dir     (sel_dir)
    );

    assign move_valid   = (state == CHASE);
    assign move         = move_valid ? sel_dir : UP;
    assign target_x     = WIDTH'(tgt_x);
    assign target_y     = HEIGHT'(tgt_y);
    assign target_valid = (state == CHASE);
    assign busy         = (state == SCAN) || (state == CHASE);
    assign done         = (state == DONE);
    assign caught       = (state == CAUGHT);
    assign dbg_state    = state;

endmodule

// File: tb/tb_pacman_pilot.sv
// Directed bench for pacman_pilot on an 8x8 maze with a scoreboard of expected values.
module tb_pacman_pilot;
    import pacman_pkg::*;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int SB_W = 32;

    logic                 clk = 1'b0;
    logic                 rst, start, catch;
    logic [W-1:0]         pacman_x, ghost_x, target_x;
    logic [H-1:0]         pacman_y, ghost_y, target_y;
    logic [W-1:0][H-1:0]  walls, candies;
    logic [1:0]           move;
    logic                 move_valid, target_valid, busy, done, caught;
    pilot_state_e         dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [SB_W-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    pacman_pilot #(.WIDTH(W), .HEIGHT(H), .STALL_LIMIT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pacman_x     (pacman_x),
        .pacman_y     (pacman_y),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .walls        (walls),
        .candies      (candies),
        .catch        (catch),
        .move         (move),
        .move_valid   (move_valid),
        .target_x     (target_x),
        .target_y     (target_y),
        .target_valid (target_valid),
        .busy         (busy),
        .done         (done),
        .caught       (caught),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    task automatic push(input logic [SB_W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [SB_W-1:0] obs);
        logic [SB_W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    // Reference nearest-candy search: x outer, y inner, strict improvement keeps the first tie.
    function automatic logic [SB_W-1:0] model_target(input int px, input int py,
                                                     input bit av, input int ax, input int ay);
        int best, bx, by, d;
        bit f;
        best = 1 << 20; bx = 0; by = 0; f = 1'b0;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                if (candies[x][y] && !(av && x == ax && y == ay)) begin
                    d = ((x > px) ? x - px : px - x) + ((y > py) ? y - py : py - y);
                    if (d < best) begin
                        best = d; bx = x; by = y; f = 1'b1;
                    end
                end
        return {15'd0, f, 8'(bx), 8'(by)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic build_map();
        walls   = '0;
        candies = '0;
        for (int i = 0; i < W; i++) begin
            walls[i][0] = 1'b1; walls[i][H-1] = 1'b1;
            walls[0][i] = 1'b1; walls[W-1][i] = 1'b1;
        end
        walls[2][2] = 1'b1; walls[3][3] = 1'b1; walls[4][4] = 1'b1;
        walls[5][5] = 1'b1; walls[5][6] = 1'b1;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                candies[x][y] = !walls[x][y];
        candies[1][1] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; catch = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic count_scan(output int n);
        n = 0;
        while (busy && !move_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic set_pos(input int px, input int py, input int gx, input int gy);
        pacman_x = 8'(px); pacman_y = 8'(py);
        ghost_x  = 8'(gx); ghost_y  = 8'(gy);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [SB_W-1:0] t;
        rst = 1'b1; start = 1'b0; catch = 1'b0;
        pacman_x = 8'd1; pacman_y = 8'd1; ghost_x = 8'd6; ghost_y = 8'd1;
        build_map();
        @(negedge clk); @(negedge clk);

        push(0); check("rst_busy", 32'(busy));
        push(0); check("rst_move_valid", 32'(move_valid));
        push(0); check("rst_move", 32'(move));
        push(0); check("rst_target_valid", 32'(target_valid));
        push(0); check("rst_target_x", 32'(target_x));
        push(32'(IDLE)); check("rst_state", 32'(dbg_state));
        rst = 1'b0;

        catch = 1'b1;
        push(32'(IDLE)); push(0);
        @(negedge clk);
        catch = 1'b0;
        check("idle_ignores_catch", 32'(dbg_state));
        check("idle_caught", 32'(caught));

        // First scan from (1,1)
        t = model_target(1, 1, 1'b0, 0, 0);
        push(64); push(32'(t[15:8])); push(32'(t[7:0])); push(32'(DOWN)); push(1); push(1);
        pulse_start();
        count_scan(n);
        check("scan1_cycles", 32'(n));
        check("scan1_target_x", 32'(target_x));
        check("scan1_target_y", 32'(target_y));
        check("scan1_move", 32'(move));
        check("scan1_move_valid", 32'(move_valid));
        check("scan1_target_valid", 32'(target_valid));

        // Hold position: target abandoned after the stall window
        push(16); push(0); push(1);
        n = 0;
        while (move_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n));
        check("stall_target_valid", 32'(target_valid));
        check("stall_busy", 32'(busy));

        t = model_target(1, 1, 1'b1, 1, 2);
        push(64); push(32'(t[15:8])); push(32'(t[7:0])); push(32'(RIGHT));
        count_scan(n);
        check("scan2_cycles", 32'(n));
        check("scan2_target_x", 32'(target_x));
        check("scan2_target_y", 32'(target_y));
        check("scan2_move", 32'(move));

        // Target candy eaten: rescan
        candies[2][1] = 1'b0;
        push(0); push(0); push(1); push(0);
        @(negedge clk);
        check("eaten_target_valid", 32'(target_valid));
        check("eaten_move_valid", 32'(move_valid));
        check("eaten_busy", 32'(busy));
        check("eaten_move", 32'(move));
        t = model_target(1, 1, 1'b1, 1, 2);
        push(64); push(32'(t[15:8])); push(32'(t[7:0]));
        count_scan(n);
        check("scan3_cycles", 32'(n));
        check("scan3_target_x", 32'(target_x));
        check("scan3_target_y", 32'(target_y));

        // Steering toward (1,3) from several positions, within one low phase
        push(32'(LEFT));  set_pos(3, 1, 6, 1); check("dir_left", 32'(move));
        push(32'(UP));    set_pos(1, 5, 6, 1); check("dir_up", 32'(move));
        push(32'(UP));    set_pos(4, 3, 6, 1); check("dir_fallback_up", 32'(move));
        push(32'(DOWN));  set_pos(1, 1, 6, 1); check("dir_down", 32'(move));
`ifdef PACMAN_PILOT_GHOST_AVOID_EN
        push(32'(RIGHT));
`else
        push(32'(DOWN));
`endif
        set_pos(1, 1, 1, 3); check("dir_ghost_target", 32'(move));
        push(32'(DOWN));  set_pos(1, 2, 1, 2); check("dir_all_near_ghost", 32'(move));
        set_pos(1, 1, 6, 1);

        // Caught during CHASE, then terminal
        catch = 1'b1;
        push(1); push(0); push(0); push(0);
        @(negedge clk);
        catch = 1'b0;
        check("caught_flag", 32'(caught));
        check("caught_busy", 32'(busy));
        check("caught_move_valid", 32'(move_valid));
        check("caught_move", 32'(move));
        push(1); push(0);
        pulse_start();
        @(negedge clk);
        check("caught_start_ignored", 32'(caught));
        check("caught_start_busy", 32'(busy));

        // Reset clears the abandoned cell; then reset asynchronously mid-CHASE
        do_reset();
        build_map();
        t = model_target(1, 1, 1'b0, 0, 0);
        push(64); push(32'(t[15:8])); push(32'(t[7:0])); push(1);
        pulse_start();
        count_scan(n);
        check("scan4_cycles", 32'(n));
        check("scan4_target_x", 32'(target_x));
        check("scan4_target_y", 32'(target_y));
        check("scan4_move_valid", 32'(move_valid));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        push(0); check("async_move", 32'(move));
        push(0); check("async_move_valid", 32'(move_valid));
        push(0); check("async_target_x", 32'(target_x));
        push(0); check("async_target_y", 32'(target_y));
        push(0); check("async_target_valid", 32'(target_valid));
        push(0); check("async_busy", 32'(busy));
        push(0); check("async_done", 32'(done));
        push(0); check("async_caught", 32'(caught));
        @(negedge clk);
        rst = 1'b0;

        // No candies: straight to DONE
        candies = '0;
        push(64); push(1); push(0); push(0); push(0);
        pulse_start();
        count_scan(n);
        check("empty_scan_cycles", 32'(n));
        check("empty_done", 32'(done));
        check("empty_move_valid", 32'(move_valid));
        check("empty_target_valid", 32'(target_valid));
        check("empty_busy", 32'(busy));
        push(1);
        pulse_start();
        @(negedge clk);
        check("done_start_ignored", 32'(done));
        catch = 1'b1;
        push(1);
        @(negedge clk);
        catch = 1'b0;
        check("done_then_catch", 32'(caught));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
